mld_7_4_encoder_ctrl: RTL and testbench

Sequencing controller for the (7,4) cyclic encoder in the majority-logic-decoder datapath. It accepts 4-bit message words on a valid/ready handshake and buffers one word ahead. It serializes each word into the encoder's `information_bit` input and drives `sel` through the 4-cycle information phase and the 3-cycle parity phase. Codewords stream back-to-back with no bubble, or with a programmable idle gap, and the block counts completed codewords.

---
 rtl/mld_7_4_encoder_ctrl_if.sv | 27 ++
 rtl/mld_7_4_encoder_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mld_7_4_encoder_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mld_7_4_encoder_ctrl_if.sv
// Message-word handshake bundle feeding the (7,4) encoder sequencer.
// Latency: none (plain wires); the sequencer registers what it accepts.
// Backpressure: msg_ready low means the one-deep word buffer is occupied.
//
// Ports / signals:
//   msg_valid  master -> slave : msg_data carries a word to be encoded
//   msg_data   master -> slave : 4-bit message word
//   msg_ready  slave -> master : buffer slot free; transfer on valid && ready
interface mld_7_4_encoder_ctrl_if;
    logic       msg_valid;
    logic       msg_ready;
    logic [3:0] msg_data;

    // Word producer.
    modport master (
        output msg_valid,
        output msg_data,
        input  msg_ready
    );

    // Sequencer side.
    modport slave (
        input  msg_valid,
        input  msg_data,
        output msg_ready
    );
endinterface

// File: rtl/mld_7_4_encoder_ctrl.sv
// Sequencer for the (7,4) cyclic encoder: serializes buffered 4-bit words, drives sel/enc_reset.
// Latency: word accepted at edge k (idle, enabled) -> first code bit registered at edge k+1.
// Backpressure: msg_ready = !next_valid; one word buffered ahead of the word being serialized.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset; aborts any codeword in flight
//   enable          allows a new codeword to start (never cuts one short)
//   msg             slave modport: msg_valid / msg_data in, msg_ready out
//   information_bit serial bit to the encoder (0 outside the information phase)
//   sel             0 = information phase, 1 = parity phase
//   enc_reset       active-high clear to the encoder while no codeword is running
//   bit_valid       information_bit / sel belong to a codeword
//   frame_start     pulse on the first bit of a codeword
//   frame_end       pulse on the seventh bit of a codeword
//   word_count      completed codewords, wraps at 2**CNT_W
module mld_7_4_encoder_ctrl #(
    parameter bit MSB_FIRST = 1'b1,   // 1: msg[3] first, 0: msg[0] first
    parameter int GAP       = 0,      // idle cycles after each codeword, 0..15
    parameter int CNT_W     = 16      // width of word_count
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    mld_7_4_encoder_ctrl_if.slave msg,
    output logic                 information_bit,
    output logic                 sel,
    output logic                 enc_reset,
    output logic                 bit_valid,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic [CNT_W-1:0]     word_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INFO   = 2'd1,
        ST_PARITY = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    // Gap counter preload; only meaningful when GAP > 0.
    localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

    localparam logic [2:0] PH_FIRST     = 3'd0;
    localparam logic [2:0] PH_LAST_INFO = 3'd3;
    localparam logic [2:0] PH_PARITY0   = 3'd4;
    localparam logic [2:0] PH_LAST      = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     state;
    logic [2:0] phase;
    logic [3:0] gap_cnt;
    logic [3:0] cur_word;     // bits not yet sent, next one sits at the serial end
    logic [3:0] next_word;
    logic       next_valid;

    // ------------------------------------------------------------------
    // Next-state signals
    // ------------------------------------------------------------------
    state_t     state_nxt;
    logic [2:0] phase_nxt;
    logic [3:0] gap_cnt_nxt;
    logic [3:0] cur_word_nxt;
    logic [3:0] next_word_nxt;
    logic       next_valid_nxt;
    logic       load;
    logic       accept;
    logic       start_ok;
    logic       count_inc;

    logic             info_bit_nxt;
    logic             sel_nxt;
    logic             enc_reset_nxt;
    logic             bit_valid_nxt;
    logic             frame_start_nxt;
    logic             frame_end_nxt;
    logic [CNT_W-1:0] word_count_nxt;

    // Bit that goes out next from a (remaining) word.
    function automatic logic first_bit(input logic [3:0] w);
        return MSB_FIRST ? w[3] : w[0];
    endfunction

    // Drop the bit just sent so the following one reaches the serial end.
    function automatic logic [3:0] shift_word(input logic [3:0] w);
        return MSB_FIRST ? {w[2:0], 1'b0} : {1'b0, w[3:1]};
    endfunction

    // The buffer slot is free whenever nothing is waiting in it. Because
    // load only happens with next_valid set, load and accept never coincide:
    // a slot freed by a load becomes visible one cycle later.
    assign msg.msg_ready = !next_valid;
    assign accept        = msg.msg_valid && !next_valid;
    assign start_ok      = next_valid && enable;

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        phase_nxt    = phase;
        gap_cnt_nxt  = gap_cnt;
        cur_word_nxt = cur_word;
        load         = 1'b0;
        count_inc    = 1'b0;
        info_bit_nxt = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    load = 1'b1;
                end
            end

            ST_INFO: begin
                if (phase == PH_LAST_INFO) begin
                    state_nxt = ST_PARITY;
                    phase_nxt = PH_PARITY0;
                end else begin
                    phase_nxt    = phase + 3'd1;
                    info_bit_nxt = first_bit(cur_word);
                    cur_word_nxt = shift_word(cur_word);
                end
            end

            ST_PARITY: begin
                if (phase == PH_LAST) begin
                    count_inc = 1'b1;
                    if (GAP > 0) begin
                        state_nxt   = ST_GAP;
                        gap_cnt_nxt = GAP_LAST;
                    end else if (start_ok) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end

            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    if (start_ok) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt - 4'd1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Starting a codeword looks the same from every state: the buffered
        // word moves into the shifter and its first bit goes out right away.
        if (load) begin
            state_nxt    = ST_INFO;
            phase_nxt    = PH_FIRST;
            info_bit_nxt = first_bit(next_word);
            cur_word_nxt = shift_word(next_word);
        end

        next_word_nxt  = next_word;
        next_valid_nxt = next_valid;
        if (load) begin
            next_valid_nxt = 1'b0;
        end else if (accept) begin
            next_valid_nxt = 1'b1;
            next_word_nxt  = msg.msg_data;
        end

        // Outputs are registered, so they are derived from where the FSM goes.
        sel_nxt         = (state_nxt == ST_PARITY);
        bit_valid_nxt   = (state_nxt == ST_INFO) || (state_nxt == ST_PARITY);
        enc_reset_nxt   = (state_nxt == ST_IDLE) || (state_nxt == ST_GAP);
        frame_start_nxt = load;
        frame_end_nxt   = (state_nxt == ST_PARITY) && (phase_nxt == PH_LAST);
        word_count_nxt  = word_count + (count_inc ? CNT_W'(1) : CNT_W'(0));
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            phase           <= 3'd0;
            gap_cnt         <= 4'd0;
            cur_word        <= 4'd0;
            next_word       <= 4'd0;
            next_valid      <= 1'b0;
            information_bit <= 1'b0;
            sel             <= 1'b0;
            enc_reset       <= 1'b1;
            bit_valid       <= 1'b0;
            frame_start     <= 1'b0;
            frame_end       <= 1'b0;
            word_count      <= '0;
        end else begin
            state           <= state_nxt;
            phase           <= phase_nxt;
            gap_cnt         <= gap_cnt_nxt;
            cur_word        <= cur_word_nxt;
            next_word       <= next_word_nxt;
            next_valid      <= next_valid_nxt;
            information_bit <= info_bit_nxt;
            sel             <= sel_nxt;
            enc_reset       <= enc_reset_nxt;
            bit_valid       <= bit_valid_nxt;
            frame_start     <= frame_start_nxt;
            frame_end       <= frame_end_nxt;
            word_count      <= word_count_nxt;
        end
    end

endmodule

// File: tb/tb_mld_7_4_encoder_ctrl.sv
// Bench for mld_7_4_encoder_ctrl: two instances (MSB-first/no gap, LSB-first/gap 2/3-bit count).
// Latency: expected outputs come from a codeword-schedule model, compared every cycle.
// Backpressure: producers hold each word until the model says the buffer took it.
module tb_mld_7_4_encoder_ctrl;

    typedef struct packed {
        logic ib;
        logic sel;
        logic bv;
        logic fs;
        logic fe;
        logic er;
    } slot_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] en;

    mld_7_4_encoder_ctrl_if if0 ();
    mld_7_4_encoder_ctrl_if if1 ();

    logic [1:0]  ib, sl, er, bv, fs, fe;
    logic [15:0] wc0;
    logic [2:0]  wc1;

    mld_7_4_encoder_ctrl #(.MSB_FIRST(1'b1), .GAP(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .enable(en[0]), .msg(if0),
        .information_bit(ib[0]), .sel(sl[0]), .enc_reset(er[0]), .bit_valid(bv[0]),
        .frame_start(fs[0]), .frame_end(fe[0]), .word_count(wc0)
    );

    mld_7_4_encoder_ctrl #(.MSB_FIRST(1'b0), .GAP(2), .CNT_W(3)) u1 (
        .clk(clk), .reset(reset), .enable(en[1]), .msg(if1),
        .information_bit(ib[1]), .sel(sl[1]), .enc_reset(er[1]), .bit_valid(bv[1]),
        .frame_start(fs[1]), .frame_end(fe[1]), .word_count(wc1)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: a codeword is a list of 7+GAP output slots.
    slot_t      sched [2][16];
    int         len [2];
    int         pos [2];
    slot_t      expv [2];
    logic       bufv [2];
    logic [3:0] bufw [2];
    int         cnt [2];

    // Producers' word lists.
    logic [3:0] src [2][1024];
    int         src_wr [2];
    int         src_rd [2];
    logic [1:0] drv_vld;
    logic [3:0] drv_dat [2];

    // Observed-trace helpers.
    int          bv_cnt [2];
    int          run [2];
    int          max_run [2];
    int          since_fe [2];
    int          last_gap [2];
    logic [31:0] ib_cap [2];
    logic [31:0] sel_cap [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, want, $time);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit msb_of(input int d);
        return (d == 0);
    endfunction

    function automatic int mask_of(input int d);
        return (d == 0) ? 32'hFFFF : 32'h7;
    endfunction

    function automatic slot_t idle_slot();
        slot_t s;
        s    = '0;
        s.er = 1'b1;
        return s;
    endfunction

    task automatic build(input int d, input logic [3:0] w);
        slot_t s;
        for (int p = 0; p < 7 + gap_of(d); p++) begin
            s = idle_slot();
            if (p < 7) begin
                s.er = 1'b0;
                s.bv = 1'b1;
            end
            if (p < 4) begin
                s.fs = (p == 0);
                s.ib = msb_of(d) ? w[3 - p] : w[p];
            end else if (p < 7) begin
                s.sel = 1'b1;
                s.fe  = (p == 6);
            end
            sched[d][p] = s;
        end
        len[d] = 7 + gap_of(d);
        pos[d] = 0;
    endtask

    task automatic model_reset(input int d);
        len[d]    = 0;
        pos[d]    = 0;
        expv[d]   = idle_slot();
        bufv[d]   = 1'b0;
        bufw[d]   = 4'd0;
        cnt[d]    = 0;
        src_rd[d] = src_wr[d];
    endtask

    task automatic model_edge(input int d);
        logic old;
        if (expv[d].fe) cnt[d] = (cnt[d] + 1) & mask_of(d);
        old = bufv[d];
        if (pos[d] >= len[d] && old && en[d]) begin
            build(d, bufw[d]);
            bufv[d] = 1'b0;
        end
        if (pos[d] < len[d]) begin
            expv[d] = sched[d][pos[d]];
            pos[d]++;
        end else begin
            expv[d] = idle_slot();
        end
        if (drv_vld[d] && !old) begin
            bufw[d] = drv_dat[d];
            bufv[d] = 1'b1;
            src_rd[d]++;
        end
    endtask

    task automatic clear_trace(input int d);
        bv_cnt[d]   = 0;
        run[d]      = 0;
        max_run[d]  = 0;
        since_fe[d] = 99;
        last_gap[d] = -1;
        ib_cap[d]   = '0;
        sel_cap[d]  = '0;
    endtask

    task automatic check_dut(input int d);
        logic        rdy;
        logic [31:0] wc;
        rdy = (d == 0) ? if0.msg_ready : if1.msg_ready;
        wc  = (d == 0) ? 32'(wc0) : 32'(wc1);
        chk($sformatf("d%0d_information_bit", d), 32'(ib[d]), 32'(expv[d].ib));
        chk($sformatf("d%0d_sel", d),             32'(sl[d]), 32'(expv[d].sel));
        chk($sformatf("d%0d_bit_valid", d),       32'(bv[d]), 32'(expv[d].bv));
        chk($sformatf("d%0d_frame_start", d),     32'(fs[d]), 32'(expv[d].fs));
        chk($sformatf("d%0d_frame_end", d),       32'(fe[d]), 32'(expv[d].fe));
        chk($sformatf("d%0d_enc_reset", d),       32'(er[d]), 32'(expv[d].er));
        chk($sformatf("d%0d_msg_ready", d),       32'(rdy),   32'(!bufv[d]));
        chk($sformatf("d%0d_word_count", d),      wc,         32'(cnt[d]));
        if (bv[d]) begin
            bv_cnt[d]++;
            run[d]++;
            if (run[d] > max_run[d]) max_run[d] = run[d];
            sel_cap[d] = {sel_cap[d][30:0], sl[d]};
            if (!sl[d]) ib_cap[d] = {ib_cap[d][30:0], ib[d]};
        end else begin
            run[d] = 0;
        end
        if (fs[d]) last_gap[d] = since_fe[d];
        if (fe[d]) since_fe[d] = 0;
        else       since_fe[d]++;
    endtask

    task automatic drive_all();
        for (int d = 0; d < 2; d++) begin
            drv_vld[d] = (src_rd[d] != src_wr[d]);
            drv_dat[d] = src[d][src_rd[d] % 1024];
        end
        if0.msg_valid = drv_vld[0];
        if0.msg_data  = drv_dat[0];
        if1.msg_valid = drv_vld[1];
        if1.msg_data  = drv_dat[1];
    endtask

    task automatic push(input int d, input logic [3:0] w);
        src[d][src_wr[d] % 1024] = w;
        src_wr[d]++;
    endtask

    // One clock: model steps on the rising edge, DUT is sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d);
        drive_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 2'b11;
        for (int d = 0; d < 2; d++) begin
            src_wr[d] = 0;
            src_rd[d] = 0;
            model_reset(d);
            clear_trace(d);
        end
        drv_vld = 2'b00;
        drv_dat[0] = 4'd0;
        drv_dat[1] = 4'd0;
        drive_all();

        // Reset held for two rising edges, then quiet idle.
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d);
        @(negedge clk);
        reset = 1'b1;
        drive_all();
        repeat (20) cycle();
        chk("idle_wc0", 32'(wc0), 32'd0);

        // Single word 1011, MSB first; latency one edge after acceptance.
        clear_trace(0);
        push(0, 4'hB);
        drive_all();
        cycle();
        chk("single_lat_accept_edge", 32'(bv[0]), 32'd0);
        cycle();
        chk("single_lat_first_bit", 32'(fs[0]), 32'd1);
        repeat (10) cycle();
        chk("single_bits", 32'(ib_cap[0][3:0]), 32'hB);
        chk("single_bv_cycles", 32'(bv_cnt[0]), 32'd7);
        chk("single_wc", 32'(wc0), 32'd1);
        chk("single_idle_enc_reset", 32'(er[0]), 32'd1);

        // Back-to-back 9, 6, F with no gap.
        clear_trace(0);
        push(0, 4'h9);
        push(0, 4'h6);
        push(0, 4'hF);
        drive_all();
        repeat (30) cycle();
        chk("b2b_contig_bv", 32'(max_run[0]), 32'd21);
        chk("b2b_sel_pattern", 32'(sel_cap[0][20:0]), 32'b000011100001110000111);
        chk("b2b_bits", 32'(ib_cap[0][11:0]), 32'h96F);
        chk("b2b_no_bubble", 32'(last_gap[0]), 32'd0);
        chk("b2b_wc", 32'(wc0), 32'd4);

        // Gap of 2, LSB first: 1 then 8.
        clear_trace(1);
        push(1, 4'h1);
        push(1, 4'h8);
        drive_all();
        repeat (30) cycle();
        chk("gap_bits", 32'(ib_cap[1][7:0]), 32'b10000001);
        chk("gap_bv_cycles", 32'(bv_cnt[1]), 32'd14);
        chk("gap_longest_run", 32'(max_run[1]), 32'd7);
        chk("gap_len", 32'(last_gap[1]), 32'd2);
        chk("gap_wc", 32'(wc1), 32'd2);

        // Enable hold with 5 buffered, then drop enable in phase 2.
        en[0] = 1'b0;
        push(0, 4'h5);
        drive_all();
        repeat (6) cycle();
        chk("hold_ready", 32'(if0.msg_ready), 32'd0);
        chk("hold_bv", 32'(bv[0]), 32'd0);
        clear_trace(0);
        en[0] = 1'b1;
        chk("en_rise_no_bit_yet", 32'(bv[0]), 32'd0);
        cycle();
        chk("en_rise_first_bit", 32'(fs[0]), 32'd1);
        cycle();
        cycle();
        en[0] = 1'b0;
        push(0, 4'h3);
        drive_all();
        repeat (12) cycle();
        chk("en_drop_completes", 32'(bv_cnt[0]), 32'd7);
        chk("en_drop_blocks_next", 32'(if0.msg_ready), 32'd0);
        chk("en_drop_wc", 32'(wc0), 32'd5);
        en[0] = 1'b1;
        repeat (10) cycle();
        chk("en_resume_wc", 32'(wc0), 32'd6);

        // Asynchronous reset in the first parity cycle with a word buffered.
        push(0, 4'hA);
        push(0, 4'hC);
        drive_all();
        for (int i = 0; i < 20; i++) begin
            if (pos[0] == 5 && len[0] > 0) break;
            cycle();
        end
        chk("rst_pre_parity", 32'(sl[0]), 32'd1);
        chk("rst_pre_buffered", 32'(if0.msg_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) model_reset(d);
        for (int d = 0; d < 2; d++) check_dut(d);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive_all();
        clear_trace(0);
        repeat (15) cycle();
        chk("rst_no_codeword", 32'(bv_cnt[0]), 32'd0);
        chk("rst_wc", 32'(wc0), 32'd0);

        // Randomized traffic and enable, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                if ((src_wr[d] - src_rd[d]) < 3 && $urandom_range(0, 2) == 0)
                    push(d, 4'($urandom_range(0, 15)));
                en[d] = ($urandom_range(0, 7) != 0);
            end
            drive_all();
            cycle();
        end
        en = 2'b11;
        repeat (60) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
